// File: rtl/muldiv_if.sv
// Request/result bundle for muldiv_unit: operation strobe and operands in,
// HI/LO result registers and status out.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, opA, opB,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, opA, opB,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers:
// one bit per cycle, shift-add multiply and restoring divide on magnitudes.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [1:0]  state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [63:0] acc_q,     acc_d;
    logic [31:0] b_q,       b_d;
    logic        is_div_q,  is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] div_next;
    logic [63:0] step_res;
    logic [63:0] prod_fixed;

    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_mag     = (is_signed && bus.opA[31]) ? -bus.opA : bus.opA;
    assign b_mag     = (is_signed && bus.opB[31]) ? -bus.opB : bus.opB;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc holds {partial remainder, dividend bits becoming quotient}.
    assign rem_sh   = acc_q[63:31];
    assign rem_ge   = rem_sh >= {1'b0, b_q};
    assign rem_sub  = rem_sh[31:0] - b_q;
    assign div_next = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                             : {rem_sh[31:0], acc_q[30:0], 1'b0};

    assign step_res   = is_div_q ? div_next : mul_next;
    assign prod_fixed = neg_res_q ? -step_res : step_res;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = ST_RUN;
                            cnt_d     = 5'd0;
                            acc_d     = {32'd0, a_mag};
                            b_d       = b_mag;
                            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            neg_res_d = is_signed && (bus.opA[31] ^ bus.opB[31]);
                            neg_rem_d = is_signed && bus.opA[31];
                        end
                        OP_MTHI: hi_d = bus.opA;
                        OP_MTLO: lo_d = bus.opA;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 5'd1;
                acc_d = step_res;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FINISH;
                    if (is_div_q) begin
                        // With a zero divisor the remainder path already rebuilds opA.
                        hi_d = neg_rem_q ? -step_res[63:32] : step_res[63:32];
                        lo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : prod_fixed[31:0];
                    end else begin
                        hi_d = prod_fixed[63:32];
                        lo_d = prod_fixed[31:0];
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            b_q       <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_FINISH);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request strobe, qualified by op.
REQ-005 op  input  3  000 none, 001 mult (signed), 010 multu, 011 div (signed), 100 divu, 101 mthi, 110 mtlo, 111 reserved.
REQ-006 opA  input  32  multiplicand, dividend, or mthi/mtlo source.
REQ-007 opB  input  32  multiplier or divisor.
REQ-008 hi  output  32  HI register: product upper word or remainder; registered.
REQ-009 lo  output  32  LO register: product lower word or quotient; registered.
REQ-010 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new mult/div result.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FINISH: IDLE->RUN on accepted mult/div start; RUN->FINISH after 32nd iteration; FINISH->IDLE unconditionally.
REQ-013 start SHALL be accepted only in IDLE; start in RUN/FINISH SHALL be ignored without side effects.
REQ-014 start with op 000 or 111 SHALL be ignored; state, hi, lo unchanged.
REQ-015 opA/opB/op SHALL be captured at the accepting edge E0; later input changes SHALL NOT affect the result.
REQ-016 Iterations SHALL occur on edges E1..E32 (one bit per edge, shift-add multiply / restoring divide on magnitudes, 5-bit counter).
REQ-017 hi/lo SHALL be written only at E32; done=1 and busy=1 for the cycle after E32; busy=0 after E33.
REQ-018 hi/lo SHALL hold their previous values throughout RUN.
REQ-019 mult/multu: {hi,lo} = full 64-bit product; signed uses magnitudes with final negation when operand signs differ.
REQ-020 div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-021 Divide by zero (either sign): 32 cycles still elapse; hi = opA, lo = 32'hFFFFFFFF.
REQ-022 Signed overflow 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-023 mthi/mtlo in IDLE SHALL write opA into hi/lo at E0; state stays IDLE; busy and done stay 0.
REQ-024 A new start in the cycle after done (IDLE again) SHALL be accepted normally (back-to-back throughput 34 cycles).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, independent of clk.
REQ-026 Reset during RUN/FINISH SHALL abort the operation; no done pulse and no hi/lo update SHALL follow.
REQ-027 First start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-028 multu opA=FFFFFFFF, opB=FFFFFFFF -> done 33 cycles after E0; hi=FFFFFFFE, lo=00000001.
REQ-029 mult opA=FFFFFFFD (-3), opB=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; second start during RUN ignored.
REQ-030 div opA=FFFFFFF9 (-7), opB=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-031 divu opA=00000064, opB=0 -> hi=00000064, lo=FFFFFFFF; then div 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-032 mthi opA=12345678 then mtlo opA=9ABCDEF0 in IDLE -> hi=12345678, lo=9ABCDEF0 after each edge, busy/done never 1.
REQ-033 multu started, rst_n low 10 cycles after E0 -> busy=0, hi=lo=0 asynchronously; no done pulse after release.
